// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and default width.
package serial_add_sub_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder: sum and majority carry, purely combinational (zero latency).
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s,
   output logic cn
);

   assign s  = a ^ b ^ c;
   assign cn = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement add/sub, LSB first through one full-adder cell.
// Result and a one-cycle Done appear WIDTH edges after the accepted Start; Start is ignored while busy.
module serial_add_sub
   import serial_add_sub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Sub,
   input  logic [WIDTH-1:0] A_in,
   input  logic [WIDTH-1:0] B_in,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Overflow
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             carry;
   logic             s;
   logic             cn;
   logic             last;

   full_adder_cell u_cell (
      .a  (a_sr[0]),
      .b  (b_sr[0]),
      .c  (carry),
      .s  (s),
      .cn (cn)
   );

   assign last = (count == CW'(WIDTH - 1));

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (Start) state_nxt = ST_SHIFT;
         ST_SHIFT: if (last)  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      Busy = (state == ST_SHIFT);
   end

   // Sum bits enter at the top of a_sr so that after WIDTH shifts it holds the full result.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         count    <= '0;
         a_sr     <= '0;
         b_sr     <= '0;
         carry    <= 1'b0;
         Done     <= 1'b0;
         Sum      <= '0;
         Cout     <= 1'b0;
         Overflow <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (Start) begin
                  a_sr  <= A_in;
                  b_sr  <= Sub ? ~B_in : B_in;
                  carry <= Sub;
                  count <= '0;
               end
            end
            ST_SHIFT: begin
               a_sr  <= {s, a_sr[WIDTH-1:1]};
               b_sr  <= b_sr >> 1;
               carry <= cn;
               count <= count + 1'b1;
               if (last) begin
                  Sum      <= {s, a_sr[WIDTH-1:1]};
                  Cout     <= cn;
                  Overflow <= carry ^ cn;
                  Done     <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_sub.sv
// Randomized and directed checks of serial_add_sub against an arithmetic reference model.
module tb_serial_add_sub;

   localparam int W = 8;

   logic         Clock;
   logic         Reset;
   logic         Start;
   logic         Sub;
   logic [W-1:0] A_in;
   logic [W-1:0] B_in;
   logic         Busy;
   logic         Done;
   logic [W-1:0] Sum;
   logic         Cout;
   logic         Overflow;

   int total;
   int passed;

   serial_add_sub #(.WIDTH(W)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Start    (Start),
      .Sub      (Sub),
      .A_in     (A_in),
      .B_in     (B_in),
      .Busy     (Busy),
      .Done     (Done),
      .Sum      (Sum),
      .Cout     (Cout),
      .Overflow (Overflow)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // {overflow, cout, sum} from plain integer arithmetic
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      int         r;
      int         sr;
      logic [W:0] rv;
      if (sub) begin
         r  = int'(a) - int'(b) + (1 << W);
         sr = int'($signed(a)) - int'($signed(b));
      end else begin
         r  = int'(a) + int'(b);
         sr = int'($signed(a)) + int'($signed(b));
      end
      rv = r[W:0];
      return {(sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1))), rv[W], rv[W-1:0]};
   endfunction

   // Called right after the accepting edge; follows the operation to Done and checks everything.
   task automatic collect(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      int           lat;
      int           busy_cnt;
      logic [W+1:0] exp;
      logic [W-1:0] held;
      lat      = 0;
      busy_cnt = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge Clock);
         if (Done) begin
            lat = i;
            break;
         end
         if (Busy) busy_cnt++;
      end
      exp = model(a, b, sub);
      check_val({tag, " latency"}, 32'(lat - 1), 32'(W));
      check_val({tag, " busy_cycles"}, 32'(busy_cnt), 32'(W));
      check_val({tag, " busy_in_done"}, 32'(Busy), 32'd0);
      check_val({tag, " sum"}, 32'(Sum), 32'(exp[W-1:0]));
      check_val({tag, " cout"}, 32'(Cout), 32'(exp[W]));
      check_val({tag, " ovf"}, 32'(Overflow), 32'(exp[W+1]));
      held = Sum;
      @(negedge Clock);
      check_val({tag, " done_pulse"}, 32'(Done), 32'd0);
      check_val({tag, " sum_hold"}, 32'(Sum), 32'(held));
   endtask

   // Call at a negedge; operands are scrambled after acceptance to prove they were latched.
   task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      A_in  = a;
      B_in  = b;
      Sub   = sub;
      Start = 1'b1;
      @(posedge Clock);
      #1;
      Start = 1'b0;
      A_in  = W'($urandom);
      B_in  = W'($urandom);
      Sub   = 1'($urandom);
      collect(tag, a, b, sub);
   endtask

   initial begin
      logic [W+1:0] exp;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rs;
      int           dones;
      int           gap;
      logic [W-1:0] done_sum;

      total  = 0;
      passed = 0;
      Reset  = 1'b1;
      Start  = 1'b0;
      Sub    = 1'b0;
      A_in   = '0;
      B_in   = '0;
      repeat (2) @(negedge Clock);
      check_val("rst busy", 32'(Busy), 32'd0);
      check_val("rst done", 32'(Done), 32'd0);
      check_val("rst sum", 32'(Sum), 32'd0);
      check_val("rst cout", 32'(Cout), 32'd0);
      check_val("rst ovf", 32'(Overflow), 32'd0);
      Reset = 1'b0;
      @(negedge Clock);

      do_op("add_35_4a", 8'h35, 8'h4A, 1'b0);
      do_op("add_7f_01", 8'h7F, 8'h01, 1'b0);
      do_op("add_ff_01", 8'hFF, 8'h01, 1'b0);
      do_op("sub_10_20", 8'h10, 8'h20, 1'b1);
      do_op("sub_80_01", 8'h80, 8'h01, 1'b1);
      do_op("sub_00_00", 8'h00, 8'h00, 1'b1);

      // Start pulse mid-operation must be ignored
      A_in  = 8'h01;
      B_in  = 8'h01;
      Sub   = 1'b0;
      Start = 1'b1;
      @(posedge Clock);
      #1;
      Start = 1'b0;
      repeat (4) @(negedge Clock);
      A_in  = 8'hAA;
      B_in  = 8'h55;
      Sub   = 1'b1;
      Start = 1'b1;
      dones    = 0;
      done_sum = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge Clock);
         Start = 1'b0;
         if (Done) begin
            dones++;
            done_sum = Sum;
         end
      end
      check_val("ignore done_count", 32'(dones), 32'd1);
      check_val("ignore sum", 32'(done_sum), 32'h02);

      // Start held high through the Done cycle launches the next operation
      A_in  = 8'h12;
      B_in  = 8'h34;
      Sub   = 1'b0;
      Start = 1'b1;
      gap   = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge Clock);
         if (Done) begin
            gap = i;
            break;
         end
      end
      check_val("b2b first_done", 32'(gap > 0), 32'd1);
      exp = model(8'h12, 8'h34, 1'b0);
      check_val("b2b first_sum", 32'(Sum), 32'(exp[W-1:0]));
      A_in = 8'h50;
      B_in = 8'h60;
      Sub  = 1'b1;
      @(posedge Clock);
      #1;
      Start = 1'b0;
      gap   = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge Clock);
         if (Done) begin
            gap = i;
            break;
         end
      end
      check_val("b2b done_gap", 32'(gap), 32'd9);
      exp = model(8'h50, 8'h60, 1'b1);
      check_val("b2b second_sum", 32'(Sum), 32'(exp[W-1:0]));
      check_val("b2b second_cout", 32'(Cout), 32'(exp[W]));
      check_val("b2b second_ovf", 32'(Overflow), 32'(exp[W+1]));
      @(negedge Clock);

      // Reset mid-operation; prior result is nonzero so the clear is observable
      do_op("pre_reset", 8'hC3, 8'h5A, 1'b0);
      A_in  = 8'h77;
      B_in  = 8'h11;
      Sub   = 1'b0;
      Start = 1'b1;
      @(posedge Clock);
      #1;
      Start = 1'b0;
      repeat (5) @(negedge Clock);
      Reset = 1'b1;
      #1;
      check_val("midrst busy", 32'(Busy), 32'd0);
      check_val("midrst done", 32'(Done), 32'd0);
      check_val("midrst sum", 32'(Sum), 32'd0);
      check_val("midrst cout", 32'(Cout), 32'd0);
      check_val("midrst ovf", 32'(Overflow), 32'd0);
      @(negedge Clock);
      Reset = 1'b0;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge Clock);
         if (Done) dones++;
      end
      check_val("midrst no_done", 32'(dones), 32'd0);
      do_op("post_reset", 8'h21, 8'h43, 1'b1);

      for (int n = 0; n < 24; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rs = 1'($urandom);
         if (n % 6 == 0) ra = 8'h80;
         if (n % 6 == 1) rb = 8'hFF;
         do_op($sformatf("rand%0d", n), ra, rb, rs);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
